// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: two-requester round-robin writeback arbiter feeding a
// single register-file write port. Grants are combinational; the selected
// write is registered and issued to the register file one cycle later.
// Writes to register 0 are accepted but never issued.
// Optional feature: define RF_WRITE_ARBITER_HAZARD_EN to build the
// read-after-write collision outputs hazard_a / hazard_b; otherwise they
// are tied low.
module rf_write_arbiter #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req0_ready,
  output logic          req1_ready,
  output logic          we,
  output logic [AW-1:0] addr_wr,
  output logic [DW-1:0] data_in,
  input  logic [AW-1:0] chk_addr_a,
  input  logic [AW-1:0] chk_addr_b,
  output logic          hazard_a,
  output logic          hazard_b
);

  // Which requester wins when both are valid.
  typedef enum logic {
    PREF_REQ0 = 1'b0,
    PREF_REQ1 = 1'b1
  } pref_e;

  pref_e         ptr_q, ptr_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  logic          grant0, grant1;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  // Grant selection: single valid wins outright, a tie goes to the pointer.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && en) begin
      if (req0_valid && req1_valid) begin
        grant0 = (ptr_q == PREF_REQ0);
        grant1 = (ptr_q == PREF_REQ1);
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Next-state: load the granted write, rotate priority away from the winner.
  always_comb begin
    sel_addr = grant1 ? req1_addr : req0_addr;
    sel_data = grant1 ? req1_data : req0_data;
    ptr_d    = ptr_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    if (grant0 || grant1) begin
      ptr_d  = grant0 ? PREF_REQ1 : PREF_REQ0;
      // Register 0 is hard-wired; the transfer completes but nothing is written.
      we_d   = (sel_addr != '0);
      addr_d = sel_addr;
      data_d = sel_data;
    end
  end

  // Write-port and priority registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      ptr_q  <= PREF_REQ0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign we      = we_q;
  assign addr_wr = addr_q;
  assign data_in = data_q;

`ifdef RF_WRITE_ARBITER_HAZARD_EN
  // A read issued to the register being written this cycle sees stale data.
  assign hazard_a = we_q && (chk_addr_a == addr_q) && (chk_addr_a != '0);
  assign hazard_b = we_q && (chk_addr_b == addr_q) && (chk_addr_b != '0);
`else
  // Collision detection not built; read addresses are intentionally ignored.
  logic unused_chk;
  assign unused_chk = ^{chk_addr_a, chk_addr_b};
  assign hazard_a   = 1'b0;
  assign hazard_b   = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter. A reference model predicts grants each
// cycle and queues the expected register-file write for the following cycle.
module tb_rf_write_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
`ifdef RF_WRITE_ARBITER_HAZARD_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          we;
  logic [AW-1:0] addr_wr;
  logic [DW-1:0] data_in;
  logic [AW-1:0] chk_addr_a, chk_addr_b;
  logic          hazard_a, hazard_b;

  int n_checks = 0;
  int n_fail   = 0;

  wr_t           sb[$];
  logic          mptr;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mdata;
  int            obs_grant;

  rf_write_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .we(we), .addr_wr(addr_wr), .data_in(data_in),
    .chk_addr_a(chk_addr_a), .chk_addr_b(chk_addr_b),
    .hazard_a(hazard_a), .hazard_b(hazard_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
  endtask

  task automatic model_reset();
    sb.delete();
    mptr  = 1'b0;
    maddr = '0;
    mdata = '0;
  endtask

  // One clock cycle: check grants against the model, queue the expected
  // write, then after the edge pop and compare the write port and hazards.
  task automatic step();
    logic g0, g1;
    wr_t  exp, got;
    #1;
    g0 = 1'b0;
    g1 = 1'b0;
    if (en) begin
      if (req0_valid && req1_valid) begin
        g0 = (mptr == 1'b0);
        g1 = (mptr == 1'b1);
      end else begin
        g0 = req0_valid;
        g1 = req1_valid;
      end
    end
    check("req0_ready", req0_ready, g0);
    check("req1_ready", req1_ready, g1);
    obs_grant = req1_ready ? 1 : (req0_ready ? 0 : -1);
    if (g0) begin
      exp.we = (req0_addr != '0); exp.addr = req0_addr; exp.data = req0_data;
      mptr = 1'b1;
    end else if (g1) begin
      exp.we = (req1_addr != '0); exp.addr = req1_addr; exp.data = req1_data;
      mptr = 1'b0;
    end else begin
      exp.we = 1'b0; exp.addr = maddr; exp.data = mdata;
    end
    maddr = exp.addr;
    mdata = exp.data;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      got = sb.pop_front();
      check("we", we, got.we);
      check("addr_wr", addr_wr, got.addr);
      check("data_in", data_in, got.data);
      check("hazard_a", hazard_a,
            HAZ && got.we && (chk_addr_a == got.addr) && (chk_addr_a != '0));
      check("hazard_b", hazard_b,
            HAZ && got.we && (chk_addr_b == got.addr) && (chk_addr_b != '0));
    end
  endtask

  initial begin
    int exp_seq[4];
    logic [AW-1:0] exp_addr[4];
    exp_seq  = '{0, 1, 0, 1};
    exp_addr = '{8'd1, 8'd2, 8'd1, 8'd2};

    // Reset state, with requests pending so ready gating is exercised.
    rst = 1'b1;
    en  = 1'b1;
    chk_addr_a = 8'd0;
    chk_addr_b = 8'd0;
    set_req(1'b1, 8'd3, 32'h11, 1'b1, 8'd4, 32'h22);
    model_reset();
    #2;
    check("rst_we", we, 1'b0);
    check("rst_addr", addr_wr, 8'd0);
    check("rst_data", data_in, 32'd0);
    check("rst_ready0", req0_ready, 1'b0);
    check("rst_ready1", req1_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Single requester 0 with a normal register.
    set_req(1'b1, 8'd5, 32'hDEADBEEF, 1'b0, 8'd0, 32'd0);
    step();
    check("single_we", we, 1'b1);
    check("single_addr", addr_wr, 8'd5);
    check("single_data", data_in, 32'hDEADBEEF);

    // Write to register 0: accepted, pointer advances, nothing written.
    set_req(1'b0, 8'd0, 32'd0, 1'b1, 8'd0, 32'h12345678);
    step();
    check("r0_grant", obs_grant, 1);
    check("r0_we", we, 1'b0);

    // Both valid continuously: strict alternation, one write per cycle.
    set_req(1'b1, 8'd1, 32'hA1A1A1A1, 1'b1, 8'd2, 32'hB2B2B2B2);
    for (int i = 0; i < 4; i++) begin
      step();
      check("alt_grant", obs_grant, exp_seq[i]);
      check("alt_addr", addr_wr, exp_addr[i]);
      check("alt_we", we, 1'b1);
    end

    // Idle cycle: write port holds address and data with we low.
    set_req(1'b0, 8'd9, 32'h9, 1'b0, 8'd9, 32'h9);
    step();

    // Write to register 7 in flight while reads probe 7 and 0, then swapped.
    chk_addr_a = 8'd7;
    chk_addr_b = 8'd0;
    set_req(1'b1, 8'd7, 32'h77777777, 1'b0, 8'd0, 32'd0);
    step();
    check("haz_a7", hazard_a, HAZ);
    check("haz_b0", hazard_b, 1'b0);
    chk_addr_a = 8'd3;
    chk_addr_b = 8'd7;
    set_req(1'b0, 8'd1, 32'h1, 1'b1, 8'd7, 32'h70707070);
    step();
    chk_addr_a = 8'd0;
    chk_addr_b = 8'd0;

    // Enable low for three cycles with both valid, then enable again.
    en = 1'b0;
    set_req(1'b1, 8'd10, 32'hAAAA0010, 1'b1, 8'd20, 32'hBBBB0020);
    for (int i = 0; i < 3; i++) begin
      step();
      check("dis_we", we, 1'b0);
    end
    en = 1'b1;
    step();
    check("en_first_grant", obs_grant, (mptr == 1'b1) ? 0 : 1);

    // Asynchronous reset between edges while transfers are streaming.
    set_req(1'b1, 8'd11, 32'hC0C0C0C0, 1'b1, 8'd12, 32'hD0D0D0D0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_we", we, 1'b0);
    check("arst_addr", addr_wr, 8'd0);
    check("arst_data", data_in, 32'd0);
    check("arst_ready0", req0_ready, 1'b0);
    check("arst_ready1", req1_ready, 1'b0);
    @(posedge clk);
    #1;
    check("arst_lost_we", we, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_ready0", req0_ready, 1'b1);
    step();
    check("rel_grant", obs_grant, 0);
    step();
    check("rel_grant2", obs_grant, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
- REQ-001 Parameter AW, default 8: register-address width.
- REQ-002 Parameter DW, default 32: register-data width.
- REQ-003 clk  input  1  single clock; all state updates on rising edge.
- REQ-004 rst  input  1  reset, asynchronous, active-high.
- REQ-005 en  input  1  arbitration enable; low means no grants are issued.
- REQ-006 req0_valid / req1_valid  input  1 each  writeback request valid.
- REQ-007 req0_addr / req1_addr  input  AW each  destination register.
- REQ-008 req0_data / req1_data  input  DW each  writeback data.
- REQ-009 req0_ready / req1_ready  output  1 each  grant; transfer occurs when valid && ready.
- REQ-010 we  output  1  register-file write enable, registered.
- REQ-011 addr_wr  output  AW  register-file write address, registered.
- REQ-012 data_in  output  DW  register-file write data, registered.
- REQ-013 chk_addr_a / chk_addr_b  input  AW each  register-file read-port addresses being issued this cycle.
- REQ-014 hazard_a / hazard_b  output  1 each  read on that port collides with the write in flight.

Function
- REQ-015 reqN_ready is combinational from en, both valids and the priority pointer.
- REQ-016 reqN_ready is never asserted while reqN_valid is low.
- REQ-017 At most one reqN_ready is high per cycle.
- REQ-018 en low: both readys are low.
- REQ-019 en high, exactly one valid: that requester is granted.
- REQ-020 en high, both valid: the requester named by the priority pointer is granted.
- REQ-021 The priority pointer is 1 bit and holds the preferred requester.
- REQ-022 After any grant to requester N, the pointer becomes 1-N; with no grant it is unchanged.
- REQ-023 Transfer in cycle T: addr_wr and data_in load the granted addr/data at the edge ending T, so the write appears in cycle T+1.
- REQ-024 The registered we is 1 in cycle T+1 only when the granted addr != 0.
- REQ-025 A write to addr 0 is accepted (ready, pointer advances) and dropped (we=0).
- REQ-026 No transfer in cycle T: we=0 in T+1; addr_wr and data_in hold their last values.
- REQ-027 Back-to-back transfers sustain one write per cycle with no bubble.
- REQ-028 An ungranted requester must hold valid/addr/data stable; the block does not buffer.
- REQ-029 hazard_x is combinational: 1 when we==1 and chk_addr_x==addr_wr and chk_addr_x!=0, else 0 (the synchronous register file returns pre-write data in that case).

Reset
- REQ-030 rst high asynchronously forces we=0, addr_wr=0, data_in=0, pointer=0.
- REQ-031 While rst is high, readys and hazards are 0.
- REQ-032 A transfer in the cycle rst asserts is lost; no partial write is emitted.
- REQ-033 First cycle after release: normal arbitration with requester 0 preferred.

Configuration
- REQ-034 Macro RF_WRITE_ARBITER_HAZARD_EN defined: hazard_a/hazard_b behave per REQ-029.
- REQ-035 Macro RF_WRITE_ARBITER_HAZARD_EN undefined: hazard_a/hazard_b are tied to 0 and the compare logic is not built; ports remain present.

Verification
- REQ-036 Reset release, req0 {addr=5, data=0xDEADBEEF} alone -> req0_ready=1; next cycle we=1, addr_wr=5, data_in=0xDEADBEEF.
- REQ-037 Both valid continuously (req0 addr=1, req1 addr=2), en=1 -> grants alternate 0,1,0,1; we=1 each cycle; addr_wr sequence 1,2,1,2.
- REQ-038 req1 {addr=0, data=0x12345678} alone -> req1_ready=1, pointer advances, next cycle we=0.
- REQ-039 en=0 with both valid for 3 cycles -> readys 0, we 0; en=1 -> pointer-preferred requester granted first.
- REQ-040 Write addr=7 in flight (we=1), chk_addr_a=7, chk_addr_b=0 -> hazard_a=1, hazard_b=0 with macro defined; both 0 without.
- REQ-041 rst pulsed mid-stream between clock edges -> we, addr_wr, data_in go 0 immediately; after release both valid -> req0 granted first.
